// File: rtl/game_session_ctrl_if.sv
// Bundle of the session controller's scan, key, game-pixel and VGA signals.
// The controller takes the slave side; the surrounding top or bench drives the master side.
interface game_session_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 10,
  parameter int COLOR_W     = 8
);
  localparam int MODE_W = $clog2(NUM_PLAYERS) + 1;

  logic [X_W-1:0]                   x;
  logic [X_W-1:0]                   y;
  logic [8*NUM_PLAYERS-1:0]         key;
  logic [3*COLOR_W*NUM_PLAYERS-1:0] game_rgb;
  logic [X_W*NUM_PLAYERS-1:0]       game_x;
  logic [NUM_PLAYERS-1:0]           start;
  logic [MODE_W-1:0]                mode;
  logic                             playing;
  logic [COLOR_W-1:0]               vga_r;
  logic [COLOR_W-1:0]               vga_g;
  logic [COLOR_W-1:0]               vga_b;

  modport master (
    output x, y, key, game_rgb,
    input  game_x, start, mode, playing, vga_r, vga_g, vga_b
  );

  modport slave (
    input  x, y, key, game_rgb,
    output game_x, start, mode, playing, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/game_session_ctrl.sv
// N-player session controller: home menu, mode select, start pulses, viewport mapping
// and registered pixel mux. Define GAME_SESSION_PAUSE_EN to add the S_PAUSE state.
module game_session_ctrl #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         X_W         = 10,
  parameter int         COLOR_W     = 8,
  parameter int         SCREEN_W    = 640,
  parameter int         VIEW_W      = 310,
  parameter int         BAND_Y0     = 160,
  parameter int         BAND_H      = 40,
  parameter logic [7:0] KEY_UP      = 8'h75,
  parameter logic [7:0] KEY_DOWN    = 8'h72,
  parameter logic [7:0] KEY_ENTER   = 8'h5a,
  parameter logic [7:0] KEY_ESC     = 8'h76
) (
  input logic                i_clk,
  input logic                i_rst,
  game_session_ctrl_if.slave bus
);

  localparam int MODE_W = $clog2(NUM_PLAYERS) + 1;
  localparam int RGB_W  = 3 * COLOR_W;

  localparam logic [RGB_W-1:0] C_GREY     = {3{COLOR_W'(50)}};
  localparam logic [RGB_W-1:0] C_MENU_SEL = {COLOR_W'(255), COLOR_W'(255), COLOR_W'(20)};
  localparam logic [RGB_W-1:0] C_MENU_BG  = {COLOR_W'(20), COLOR_W'(20), COLOR_W'(255)};

`ifdef GAME_SESSION_PAUSE_EN
  localparam logic [7:0] KEY_PAUSE = 8'h4d;
  localparam int         HIST_P    = NUM_PLAYERS;
`else
  // Without pause only player 0's keys can ever fire a command.
  localparam int         HIST_P    = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_PLAY
`ifdef GAME_SESSION_PAUSE_EN
    , S_PAUSE
`endif
  } state_t;

  state_t               state;
  logic [MODE_W-1:0]    mode_q;
  logic [NUM_PLAYERS-1:0] start_q;
  logic                 playing_q;
  logic [8*HIST_P-1:0]  key_q;
  logic [RGB_W-1:0]     vga_q;

  // Player-0 command events: a code fires only on the cycle it first appears.
  logic [7:0] key0;
  logic       key0_new;
  logic       up_evt, down_evt, enter_evt, esc_evt;

  assign key0      = bus.key[7:0];
  assign key0_new  = key0 != key_q[7:0];
  assign up_evt    = key0_new && (key0 == KEY_UP);
  assign down_evt  = key0_new && (key0 == KEY_DOWN);
  assign enter_evt = key0_new && (key0 == KEY_ENTER);
  assign esc_evt   = key0_new && (key0 == KEY_ESC);

  logic [NUM_PLAYERS-1:0] active;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    active = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      active[p] = MODE_W'(p) <= mode_q;
    end
  end

`ifdef GAME_SESSION_PAUSE_EN
  logic pause_evt;

  always_comb begin
    pause_evt = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (active[p] && (bus.key[8*p +: 8] != key_q[8*p +: 8]) &&
          (bus.key[8*p +: 8] == KEY_PAUSE)) begin
        pause_evt = 1'b1;
      end
    end
  end
`endif

  // Left margin per mode; table padded to a power of two so mode_q indexes it directly.
  logic [X_W-1:0] margin_tab [2**MODE_W];
  logic [X_W-1:0] margin;

  for (genvar m = 0; m < 2**MODE_W; m++) begin : g_margin
    if (m < NUM_PLAYERS) begin : g_used
      assign margin_tab[m] = X_W'((SCREEN_W - (m + 1) * VIEW_W) / 2);
    end else begin : g_unused
      assign margin_tab[m] = '0;
    end
  end

  assign margin = margin_tab[mode_q];

  logic [X_W*NUM_PLAYERS-1:0] game_x;
  logic                       hit;
  logic [RGB_W-1:0]           hit_rgb;

  always_comb begin
    game_x  = '0;
    hit     = 1'b0;
    hit_rgb = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      game_x[p*X_W +: X_W] = bus.x - (margin + X_W'(p * VIEW_W));
      if (active[p] && (bus.x >= margin + X_W'(p * VIEW_W)) &&
          (game_x[p*X_W +: X_W] < X_W'(VIEW_W))) begin
        hit     = 1'b1;
        hit_rgb = bus.game_rgb[p*RGB_W +: RGB_W];
      end
    end
  end

  logic [31:0] band_lo;
  logic        in_band;

  assign band_lo = 32'(BAND_Y0) + 32'(mode_q) * 32'(BAND_H);
  assign in_band = (32'(bus.y) >= band_lo) && (32'(bus.y) < band_lo + 32'(BAND_H));

  logic [RGB_W-1:0] pixel;

  always_comb begin
    pixel = C_MENU_BG;
    case (state)
      S_IDLE:  pixel = in_band ? C_MENU_SEL : C_MENU_BG;
      default: pixel = hit ? hit_rgb : C_GREY;
    endcase
`ifdef GAME_SESSION_PAUSE_EN
    // Paused games are shown at half intensity; the grey border is left alone.
    if ((state == S_PAUSE) && hit) begin
      pixel = {1'b0, hit_rgb[RGB_W-1 -: COLOR_W-1],
               1'b0, hit_rgb[2*COLOR_W-1 -: COLOR_W-1],
               1'b0, hit_rgb[COLOR_W-1 -: COLOR_W-1]};
    end
`endif
  end

  // NOTE: async reset sits in the sensitivity list; sequential state uses non-blocking only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      start_q   <= '0;
      playing_q <= 1'b0;
      key_q     <= '0;
    end else begin
      key_q   <= bus.key[8*HIST_P-1:0];
      start_q <= '0;
      case (state)
        S_IDLE: begin
          if (enter_evt) begin
            state   <= S_START;
            start_q <= active;
          end else if (up_evt && (mode_q != '0)) begin
            mode_q <= mode_q - MODE_W'(1);
          end else if (down_evt && (mode_q != MODE_W'(NUM_PLAYERS - 1))) begin
            mode_q <= mode_q + MODE_W'(1);
          end
        end
        S_START: begin
          state     <= S_PLAY;
          playing_q <= 1'b1;
        end
        S_PLAY: begin
          if (esc_evt) begin
            state     <= S_IDLE;
            playing_q <= 1'b0;
          end
`ifdef GAME_SESSION_PAUSE_EN
          else if (pause_evt) begin
            state <= S_PAUSE;
          end
`endif
        end
`ifdef GAME_SESSION_PAUSE_EN
        S_PAUSE: begin
          if (esc_evt) begin
            state     <= S_IDLE;
            playing_q <= 1'b0;
          end else if (pause_evt) begin
            state <= S_PLAY;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vga_q <= '0;
    end else begin
      vga_q <= pixel;
    end
  end

  assign bus.game_x  = game_x;
  assign bus.start   = start_q;
  assign bus.mode    = mode_q;
  assign bus.playing = playing_q;
  assign bus.vga_r   = vga_q[RGB_W-1 -: COLOR_W];
  assign bus.vga_g   = vga_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.vga_b   = vga_q[COLOR_W-1:0];

endmodule
